// File: rtl/riscv_mem_wait_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : riscv_mem_wait_ctrl_if
// Brief   : Request/response bundle between a fetch/LSU requester and the
//           on-chip RAM wait-state generator.
// Revision: 1.0 - initial release
// ============================================================================
interface riscv_mem_wait_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 4
);
    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [CNT_W-1:0]  cfg_lat;
    logic              mem_ready;
    logic              busy;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;

    modport master (
        output rden, wren, addr, flush, cfg_lat,
        input  mem_ready, busy, addr_q, we_q
    );

    modport slave (
        input  rden, wren, addr, flush, cfg_lat,
        output mem_ready, busy, addr_q, we_q
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : riscv_mem_wait_ctrl
// Brief   : Wait-state generator turning a level read/write request into a
//           single-cycle mem_ready pulse after a configurable latency.
// Revision: 1.0 - initial release
// ============================================================================
module riscv_mem_wait_ctrl #(
    parameter int ADDR_W      = 64,
    parameter int LATENCY     = 4,
    parameter int MAX_LATENCY = 15,
    parameter int CNT_W       = $clog2(MAX_LATENCY + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    riscv_mem_wait_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] C_LAT = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_LATENCY);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic              rdy_q, rdy_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic              cap_we_q, cap_we_d;

    logic              w_req;
    logic              w_changed;
    logic [CNT_W-1:0]  w_eff_lat;
    logic              w_busy;

    assign w_req     = bus.rden | bus.wren;
    assign w_changed = (bus.addr != cap_addr_q) || (bus.wren != cap_we_q);

    // Zero selects the build-time default; oversized values saturate.
    assign w_eff_lat = (bus.cfg_lat == C_ZERO) ? C_LAT :
                       ((bus.cfg_lat > C_MAX) ? C_MAX : bus.cfg_lat);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lat_q      <= '0;
            rdy_q      <= 1'b0;
            cap_addr_q <= '0;
            cap_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            rdy_q      <= rdy_d;
            cap_addr_q <= cap_addr_d;
            cap_we_q   <= cap_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        rdy_d      = 1'b0;
        cap_addr_d = cap_addr_q;
        cap_we_d   = cap_we_q;

        if (bus.flush) begin
            // Flush outranks everything, including a completion due now.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_req) begin
                        cap_addr_d = bus.addr;
                        cap_we_d   = bus.wren;
                        lat_d      = w_eff_lat;
                        cnt_d      = C_ONE;
                        if (w_eff_lat == C_ONE) begin
                            state_d = S_DONE;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end

                S_WAIT: begin
                    if (!w_req) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (w_changed) begin
                        // A new address or direction restarts the full latency.
                        cap_addr_d = bus.addr;
                        cap_we_d   = bus.wren;
                        lat_d      = w_eff_lat;
                        cnt_d      = C_ONE;
                        if (w_eff_lat == C_ONE) begin
                            state_d = S_DONE;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else if (cnt_q == (lat_q - C_ONE)) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = (state_q == S_WAIT);
    end

    assign bus.mem_ready = rdy_q;
    assign bus.busy      = w_busy;
    assign bus.addr_q    = cap_addr_q;
    assign bus.we_q      = cap_we_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_mem_wait_ctrl
// Brief   : Directed self-checking bench for the memory wait-state generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscv_mem_wait_ctrl;

    localparam int ADDR_W      = 64;
    localparam int LATENCY     = 4;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    riscv_mem_wait_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    riscv_mem_wait_ctrl #(
        .ADDR_W     (ADDR_W),
        .LATENCY    (LATENCY),
        .MAX_LATENCY(MAX_LATENCY),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call moves to the next cycle; outputs are settled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.rden    = 1'b0;
        bus.wren    = 1'b0;
        bus.flush   = 1'b0;
        bus.cfg_lat = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_bus();
        bus.addr = 64'h0;

        // Reset state
        tick();
        chk("rst_ready", bus.mem_ready, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_addr",  bus.addr_q, 0);
        chk("rst_we",    bus.we_q, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: default latency, request dropped at mem_ready
        bus.rden = 1'b1;
        bus.addr = 64'hDEAD_BEEF_0000_1230;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) bus.rden = 1'b0;
            chk("t1_ready", bus.mem_ready, (k == 4) ? 1 : 0);
            chk("t1_busy",  bus.busy, (k >= 1 && k <= 3) ? 1 : 0);
            if (k == 4) begin
                chk("t1_we",   bus.we_q, 0);
                chk("t1_addr", bus.addr_q, 64'hDEAD_BEEF_0000_1230);
            end
        end

        // 2: held request gives back-to-back completions every L cycles
        bus.rden = 1'b1;
        bus.addr = 64'h40;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 13) bus.rden = 1'b0;
            chk("t2_ready", bus.mem_ready, (k == 4 || k == 8 || k == 12) ? 1 : 0);
        end
        idle_bus();
        tick();

        // 3: request dropped in cycle 2 aborts without a pulse
        bus.rden = 1'b1;
        bus.addr = 64'h80;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) bus.rden = 1'b0;
            chk("t3_ready", bus.mem_ready, 0);
            chk("t3_busy",  bus.busy, (k == 1 || k == 2) ? 1 : 0);
        end

        // 4: address change mid-wait restarts the latency
        bus.rden = 1'b1;
        bus.addr = 64'h1000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) bus.addr = 64'h2000;
            if (k == 6) bus.rden = 1'b0;
            if (k == 1) chk("t4_addr_first", bus.addr_q, 64'h1000);
            chk("t4_ready", bus.mem_ready, (k == 6) ? 1 : 0);
            if (k == 6) chk("t4_addr", bus.addr_q, 64'h2000);
        end

        // 5: single-cycle latency writes with a flush in cycle 3
        bus.wren    = 1'b1;
        bus.cfg_lat = 5'd1;
        bus.addr    = 64'h3000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.flush = (k == 3);
            if (k == 5) bus.wren = 1'b0;
            chk("t5_ready", bus.mem_ready, (k == 1 || k == 2 || k == 3 || k == 5) ? 1 : 0);
            chk("t5_busy",  bus.busy, 0);
            if (k == 1) chk("t5_we", bus.we_q, 1);
        end
        idle_bus();
        tick();

        // Flush on the edge a completion is due (L=2) suppresses it
        bus.rden    = 1'b1;
        bus.cfg_lat = 5'd2;
        bus.addr    = 64'h5550;
        tick();
        chk("fl_busy1", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        idle_bus();
        chk("fl_ready", bus.mem_ready, 0);
        chk("fl_busy2", bus.busy, 0);
        chk("fl_addr",  bus.addr_q, 64'h5550);
        tick();
        chk("fl_ready_late", bus.mem_ready, 0);

        // 6: async reset mid-wait, then an oversized cfg_lat clamps to MAX_LATENCY
        bus.wren = 1'b1;
        bus.addr = 64'h7777;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", bus.mem_ready, 0);
        chk("t6_rst_busy",  bus.busy, 0);
        chk("t6_rst_addr",  bus.addr_q, 0);
        chk("t6_rst_we",    bus.we_q, 0);
        idle_bus();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_quiet", bus.mem_ready, 0);
        end
        bus.rden    = 1'b1;
        bus.cfg_lat = 5'd20;
        bus.addr    = 64'h9000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) bus.rden = 1'b0;
            chk("t6_ready", bus.mem_ready, (k == 15) ? 1 : 0);
            if (k == 14) chk("t6_busy", bus.busy, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
